// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, ALUOp codes,
// opcodes and datapath select codes. The ALU control decoder imports the same ALUOp set.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BEQ      = 4'd8,
        S_BNE      = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_SLTI_EX  = 4'd11,
        S_IMM_WB   = 4'd12,
        S_JUMP     = 4'd13
    } state_t;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_BEQ   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_ADDI  = 3'b011;
    localparam logic [2:0] ALUOP_SLTI  = 3'b100;
    localparam logic [2:0] ALUOP_BNE   = 3'b101;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Dispatch target out of DECODE; S_FETCH doubles as the "unsupported opcode" marker.
    function automatic state_t decode_target(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW: return S_MEMADR;
            OP_RTYPE:     return S_RTYPE_EX;
            OP_BEQ:       return S_BEQ;
            OP_BNE:       return S_BNE;
            OP_ADDI:      return S_ADDI_EX;
            OP_SLTI:      return S_SLTI_EX;
            OP_J:         return S_JUMP;
            default:      return S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: sequences each instruction and
// drives every datapath enable/select plus the ALUOp for the ALU control decoder.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [5:0] OpCode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       Illegal,
    output logic [3:0] State
);

    state_t state_q;
    state_t state_d;
    logic   mem_ready;

    assign mem_ready = USE_MEM_READY ? MemReady : 1'b1;
    assign State     = state_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= S_FETCH;
            Illegal <= 1'b0;
        end else begin
            state_q <= state_d;
            Illegal <= (state_q == S_DECODE) && (decode_target(OpCode) == S_FETCH);
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:  state_d = decode_target(OpCode);
            S_MEMADR:  state_d = (OpCode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPE_EX: state_d = S_ALU_WB;
            S_ADDI_EX, S_SLTI_EX: state_d = S_IMM_WB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = PCSRC_ALU;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALUOP_ADD;
        // Reset gates the decode so strobes drop in the reset cycle itself, not one edge later.
        if (Reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: ALUSrcB = SRCB_IMM_SH;
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_RTYPE_EX: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_RTYPE;
                end
                S_ALU_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BEQ, S_BNE: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = (state_q == S_BNE) ? ALUOP_BNE : ALUOP_BEQ;
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                end
                S_ADDI_EX, S_SLTI_EX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = (state_q == S_SLTI_EX) ? ALUOP_SLTI : ALUOP_ADDI;
                end
                S_IMM_WB: RegWrite = 1'b1;
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_JUMP;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each step pushes the expected state/outputs
// to a scoreboard queue and pops it against the DUT mid-cycle.
module tb_multicycle_control;

    localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5, RX = 6, AWB = 7;
    localparam int BQ = 8, BN = 9, AX = 10, SX = 11, IWB = 12, JP = 13;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, SLTI = 6'b001010, J = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       memto_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       illegal;
    } obs_t;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [5:0] OpCode = 6'd0;
    logic       MemReady = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Illegal;
    logic [1:0] PCSource, ALUSrcB;
    logic [2:0] ALUOp;
    logic [3:0] State;

    obs_t  sb_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    multicycle_control #(.USE_MEM_READY(1'b1)) dut (
        .Clock(Clock), .Reset(Reset), .OpCode(OpCode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .Illegal(Illegal), .State(State)
    );

    always #5 Clock = ~Clock;

    // Reference output table, one entry per state as listed in the control table.
    function automatic obs_t ref_ctrl(input int st, input logic mr, input logic rst, input logic ill);
        obs_t o;
        o         = '0;
        o.state   = 4'(st);
        o.illegal = ill;
        if (rst) begin
            case (st)
                F:   begin o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
                D:   o.alu_src_b = 2'b11;
                MA:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
                MR:  begin o.mem_read = 1'b1; o.iord = 1'b1; end
                MWB: begin o.reg_write = 1'b1; o.memto_reg = 1'b1; end
                MW:  begin o.mem_write = 1'b1; o.iord = 1'b1; end
                RX:  begin o.alu_src_a = 1'b1; o.alu_op = 3'b010; end
                AWB: begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
                BQ:  begin o.alu_src_a = 1'b1; o.alu_op = 3'b001; o.pc_write_cond = 1'b1; o.pc_source = 2'b01; end
                BN:  begin o.alu_src_a = 1'b1; o.alu_op = 3'b101; o.pc_write_cond = 1'b1; o.pc_source = 2'b01; end
                AX:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = 3'b011; end
                SX:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = 3'b100; end
                IWB: o.reg_write = 1'b1;
                JP:  begin o.pc_write = 1'b1; o.pc_source = 2'b10; end
                default: ;
            endcase
        end
        return o;
    endfunction

    // One clock cycle: drive inputs, push the expectation, compare mid-cycle, advance.
    task automatic step(input string tag, input int st, input logic ill,
                        input logic rst, input logic mr, input logic [5:0] op);
        obs_t  exp_v;
        obs_t  act_v;
        string t;
        Reset    = rst;
        MemReady = mr;
        OpCode   = op;
        sb_q.push_back(ref_ctrl(st, mr, rst, ill));
        tag_q.push_back(tag);
        #2;
        exp_v = sb_q.pop_front();
        t     = tag_q.pop_front();
        act_v = {State, PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
                 MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, Illegal};
        checks++;
        assert (act_v === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", t, act_v, exp_v);
        end
        @(posedge Clock);
        #1;
    endtask

    initial begin
        @(posedge Clock);
        #1;
        // Reset, then park a store in MEMWR and reset it mid-access.
        step("rst_hold",     F,   0, 0, 0, RT);
        step("fetch_stall0", F,   0, 1, 0, SW);
        step("fetch_stall1", F,   0, 1, 0, SW);
        step("fetch_go",     F,   0, 1, 1, SW);
        step("sw_dec",       D,   0, 1, 1, SW);
        step("sw_adr",       MA,  0, 1, 0, SW);
        step("sw_wr_stall",  MW,  0, 1, 0, SW);
        step("rst_mid_wr",   MW,  0, 0, 0, SW);
        step("rst_cycle2",   F,   0, 0, 1, SW);
        step("rst_release",  F,   0, 1, 1, LW);
        // lw, no stalls: 0,1,2,3,4 then back to 0.
        step("lw_dec",       D,   0, 1, 1, LW);
        step("lw_adr",       MA,  0, 1, 1, LW);
        step("lw_rd",        MR,  0, 1, 1, LW);
        step("lw_wb",        MWB, 0, 1, 0, LW);
        // sw with three stall cycles in MEMWR.
        step("sw2_fetch",    F,   0, 1, 1, SW);
        step("sw2_dec",      D,   0, 1, 1, SW);
        step("sw2_adr",      MA,  0, 1, 1, SW);
        step("sw2_wr0",      MW,  0, 1, 0, SW);
        step("sw2_wr1",      MW,  0, 1, 0, SW);
        step("sw2_wr2",      MW,  0, 1, 0, SW);
        step("sw2_wr3",      MW,  0, 1, 1, SW);
        // R-type, beq, bne; MemReady low in non-memory states must be ignored.
        step("rt_fetch",     F,   0, 1, 1, RT);
        step("rt_dec",       D,   0, 1, 0, RT);
        step("rt_ex",        RX,  0, 1, 0, RT);
        step("rt_wb",        AWB, 0, 1, 0, RT);
        step("beq_fetch",    F,   0, 1, 1, BEQ);
        step("beq_dec",      D,   0, 1, 0, BEQ);
        step("beq_br",       BQ,  0, 1, 0, BEQ);
        step("bne_fetch",    F,   0, 1, 1, BNE);
        step("bne_dec",      D,   0, 1, 1, BNE);
        step("bne_br",       BN,  0, 1, 1, BNE);
        // addi, slti, j.
        step("addi_fetch",   F,   0, 1, 1, ADDI);
        step("addi_dec",     D,   0, 1, 1, ADDI);
        step("addi_ex",      AX,  0, 1, 1, ADDI);
        step("addi_wb",      IWB, 0, 1, 1, ADDI);
        step("slti_fetch",   F,   0, 1, 1, SLTI);
        step("slti_dec",     D,   0, 1, 1, SLTI);
        step("slti_ex",      SX,  0, 1, 0, SLTI);
        step("slti_wb",      IWB, 0, 1, 0, SLTI);
        step("j_fetch",      F,   0, 1, 1, J);
        step("j_dec",        D,   0, 1, 1, J);
        step("j_jump",       JP,  0, 1, 1, J);
        // Unsupported opcode: one-cycle Illegal pulse, then FETCH stalls on MemReady.
        step("ill_fetch",    F,   0, 1, 1, BAD);
        step("ill_dec",      D,   0, 1, 1, BAD);
        step("ill_pulse",    F,   1, 1, 0, BAD);
        step("ill_clear",    F,   0, 1, 0, BAD);
        step("ill_refetch",  F,   0, 1, 1, RT);
        step("tail_dec",     D,   0, 1, 1, RT);

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain: observed=%0d expected=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multicycle MIPS datapath. It sits directly upstream of the ALU control decoder and drives its 3-bit ALUOp. It also drives every datapath enable and mux select: PC, IR, memory, register file, ALU source muxes and PC source mux. It sequences fetch/decode/execute/memory/writeback per instruction and stalls on a memory-ready handshake.

Parameters:
USE_MEM_READY, 1, 1: FETCH/MEMRD/MEMWR wait for MemReady; 0: MemReady is treated as constant 1.

Ports:
Clock  input  1  system clock; all state updates on its rising edge
Reset  input  1  synchronous, active-low reset; sampled on the rising edge of Clock
OpCode  input  6  instruction bits [31:26] from the IR; sampled only in DECODE
MemReady  input  1  memory completes the current access this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if ALU Zero (branch)
PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target
IorD  output  1  0 PC addresses memory, 1 ALUOut addresses memory
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IRWrite  output  1  IR load
MemtoReg  output  1  register write data: 0 ALUOut, 1 MDR
RegDst  output  1  destination register: 0 rt, 1 rd
RegWrite  output  1  register file write
ALUSrcA  output  1  0 PC, 1 register A
ALUSrcB  output  2  00 B, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left 2
ALUOp  output  3  000 add (lw/sw/fetch), 001 beq, 010 R-type, 011 addi, 100 slti, 101 bne
Illegal  output  1  one-cycle pulse when an unsupported opcode is decoded
State  output  4  current state, for debug and the bench

Behaviour:
- Moore FSM with a 4-bit state register. Outputs are decoded combinationally from State; the exceptions are MemReady gating and Illegal, which is registered.
- Any output not listed for a state is 0.
- Reset low at a clock edge: State becomes FETCH and Illegal becomes 0.
- While Reset is low, PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite and RegWrite are forced to 0, ALUOp is 000 and all selects are 0.
- FETCH(0): MemRead=1, ALUSrcB=01, ALUOp=000. IRWrite and PCWrite equal MemReady. Moves to DECODE when MemReady=1, otherwise holds.
- DECODE(1): ALUSrcB=11, ALUOp=000 (branch target precompute). Next state by OpCode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> RTYPE_EX
  - 000100 (beq) -> BEQ
  - 000101 (bne) -> BNE
  - 001000 (addi) -> ADDI_EX
  - 001010 (slti) -> SLTI_EX
  - 000010 (j) -> JUMP
  - other -> FETCH, with Illegal=1 for exactly the next cycle
- MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=000. Next is MEMRD for lw, MEMWR for sw. OpCode is held stable by the IR.
- MEMRD(3): MemRead=1, IorD=1. Holds until MemReady=1, then MEMWB.
- MEMWB(4): RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
- MEMWR(5): MemWrite=1, IorD=1. Holds until MemReady=1, then FETCH.
- RTYPE_EX(6): ALUSrcA=1, ALUSrcB=00, ALUOp=010 -> ALU_WB.
- ALU_WB(7): RegWrite=1, RegDst=1 -> FETCH.
- BEQ(8): ALUSrcA=1, ALUOp=001, PCWriteCond=1, PCSource=01 -> FETCH.
- BNE(9): as BEQ but ALUOp=101 (the downstream ALU code inverts the Zero sense) -> FETCH.
- ADDI_EX(10): ALUSrcA=1, ALUSrcB=10, ALUOp=011 -> IMM_WB.
- SLTI_EX(11): as ADDI_EX but ALUOp=100 -> IMM_WB.
- IMM_WB(12): RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- JUMP(13): PCWrite=1, PCSource=10 -> FETCH.
- Unused encodings 14/15: all outputs 0; next state FETCH.
- Cycle counts with MemReady always 1:
  - lw 5 cycles; sw 4; R-type 4; addi/slti 4; beq/bne 3; j 3.
  - Each stall cycle adds one cycle.
- Reset mid-instruction (any state, including a stalled memory access): next state is FETCH. Any in-progress write strobe drops in the reset cycle.
- MemReady outside FETCH/MEMRD/MEMWR is ignored.

Decomposition:
- Package mips_ctrl_pkg:
  - state encodings, 4-bit, values 0..13
  - ALUOp codes 000..101 (shared with the ALU control decoder)
  - opcode constants
  - ALUSrcB and PCSource select codes
- No sub-module: a single next-state process plus a single output-decode process.

Test Plan:
- Reset low for 2 cycles mid-MEMWR -> State=0 and MemWrite=0 in the reset cycle. After release, MemRead=1 and ALUOp=000.
- lw (100011), MemReady=1 -> State 0,1,2,3,4,0 over 5 cycles. RegWrite=1 and MemtoReg=1 only in state 4.
- sw with MemReady low 3 cycles in MEMWR -> MemWrite=1 and IorD=1 for 4 cycles, then State=0. RegWrite is never asserted.
- R-type then beq then bne -> ALUOp=010 in state 6, 001 in state 8, 101 in state 9. PCWriteCond=1 and PCSource=01 in 8/9 only.
- addi, slti, j -> ALUOp=011 then 100 with ALUSrcB=10, RegDst=0 in state 12. JUMP gives PCWrite=1 with PCSource=10.
- OpCode 111111 in DECODE -> State=0 next cycle with Illegal=1 for exactly 1 cycle. FETCH with MemReady=0 holds State=0 with IRWrite=0 and PCWrite=0.
